// File: rtl/mips_core_pkg.sv
// Shared core types: register-file widths and the write-back entry layout.
// The key-match helper is the common notion of a pending write for a register.
package mips_core;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic                      thread;
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     data;
    } wb_entry_t;

    // r0 is hardwired zero, so it can never alias a pending write.
    function automatic logic key_match(
        input wb_entry_t                 e,
        input logic                      thread,
        input logic [REG_ADDR_WIDTH-1:0] addr
    );
        return (e.thread == thread) && (e.addr == addr) && (addr != '0);
    endfunction

endpackage

// File: rtl/write_back_queue_match.sv
// Youngest-match search over the occupied queue entries, used for operand forwarding.
// Entries are scanned oldest to youngest from the head so the last hit wins.
module wb_match_search
    import mips_core::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t                 entries [DEPTH],
    input  logic [DEPTH-1:0]          valid,
    input  logic [PTR_W-1:0]          head,
    input  logic                      key_thread,
    input  logic [REG_ADDR_WIDTH-1:0] key_addr,
    output logic                      hit,
    output logic [DATA_WIDTH-1:0]     data
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (valid[idx] && key_match(entries[idx], key_thread, key_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/write_back_queue.sv
// In-order write-back queue merging ALU and load results into one register-file port.
// The head drains every cycle it is occupied; readies are derived from registered count only.
module write_back_queue
    import mips_core::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic                      alu_thread,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rw_addr,
    input  logic [DATA_WIDTH-1:0]     alu_rw_data,

    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic                      mem_thread,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rw_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rw_data,

    output logic                      wb_uses_rw,
    output logic                      wb_thread,
    output logic [REG_ADDR_WIDTH-1:0] wb_rw_addr,
    output logic [DATA_WIDTH-1:0]     wb_rw_data,

    input  logic                      q_thread,
    input  logic [REG_ADDR_WIDTH-1:0] q_addr,
    output logic                      q_hit,
    output logic [DATA_WIDTH-1:0]     q_data,

    output logic [CNT_W-1:0]          count
);

    wb_entry_t        entries [DEPTH];
    wb_entry_t        mem_entry;
    wb_entry_t        alu_entry;
    wb_entry_t        head_entry;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] alu_slot;
    logic             mem_enq;
    logic             alu_enq;
    logic             deq;
    logic [1:0]       enq_cnt;
    logic [DEPTH-1:0] occupied;

    // alu needs two free slots so that a simultaneous mem transfer always fits ahead of it
    assign mem_ready = (count <= CNT_W'(DEPTH - 1));
    assign alu_ready = (count <= CNT_W'(DEPTH - 2));

    assign mem_entry = '{thread: mem_thread, addr: mem_rw_addr, data: mem_rw_data};
    assign alu_entry = '{thread: alu_thread, addr: alu_rw_addr, data: alu_rw_data};

    assign mem_enq  = mem_valid && mem_ready && (mem_rw_addr != '0);
    assign alu_enq  = alu_valid && alu_ready && (alu_rw_addr != '0);
    assign deq      = (count != '0);
    assign enq_cnt  = {1'b0, mem_enq} + {1'b0, alu_enq};
    assign alu_slot = mem_enq ? tail_ptr + PTR_W'(1) : tail_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + PTR_W'(deq);
            tail_ptr <= tail_ptr + PTR_W'(enq_cnt);
            count    <= count + CNT_W'(enq_cnt) - CNT_W'(deq);
        end
    end

    // Payload storage is not reset; the occupancy mask hides stale slots.
    always_ff @(posedge clk) begin
        if (mem_enq) entries[tail_ptr] <= mem_entry;
        if (alu_enq) entries[alu_slot] <= alu_entry;
    end

    always_comb begin
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = CNT_W'(PTR_W'(i) - head_ptr) < count;
        end
    end

    assign head_entry = entries[head_ptr];

    always_comb begin
        wb_uses_rw = 1'b0;
        wb_thread  = 1'b0;
        wb_rw_addr = '0;
        wb_rw_data = '0;
        if (deq) begin
            wb_uses_rw = 1'b1;
            wb_thread  = head_entry.thread;
            wb_rw_addr = head_entry.addr;
            wb_rw_data = head_entry.data;
        end
    end

    wb_match_search #(
        .DEPTH(DEPTH)
    ) u_match (
        .entries    (entries),
        .valid      (occupied),
        .head       (head_ptr),
        .key_thread (q_thread),
        .key_addr   (q_addr),
        .hit        (q_hit),
        .data       (q_data)
    );

endmodule
